// File: rtl/nn_argmax_classifier.sv
// Argmax over the final dense layer's signed score vector: snapshot on start, scan one element per cycle.
// Define NN_ARGMAX_THRESHOLD_EN to add a threshold input and a reject output ("no word" class code).
module nn_argmax_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 48,
    parameter int IDX_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] scores [0:NUM_CLASSES-1],
`ifdef NN_ARGMAX_THRESHOLD_EN
    input  logic signed [DATA_W-1:0] threshold,
    output logic                     reject,
`endif
    output logic                     busy,
    output logic                     done,
    output logic                     valid,
    output logic [IDX_W-1:0]         class_idx,
    output logic signed [DATA_W-1:0] max_score
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CLASSES - 1);
    localparam logic [IDX_W-1:0] FIRST_IDX   = IDX_W'(1);
    localparam state_t           AFTER_START = (NUM_CLASSES > 1) ? SCAN : DONE;

    state_t state, state_next;

    logic signed [DATA_W-1:0] score_buf [0:NUM_CLASSES-1];
    logic signed [DATA_W-1:0] best;
    logic signed [DATA_W-1:0] cur_score;
    logic [IDX_W-1:0]         best_idx;
    logic [IDX_W-1:0]         scan_idx;
`ifdef NN_ARGMAX_THRESHOLD_EN
    localparam logic [IDX_W-1:0] NO_WORD = IDX_W'(NUM_CLASSES);
    logic signed [DATA_W-1:0] thresh_buf;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = AFTER_START;
            SCAN:    if (scan_idx == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Element select written as a compare chain so the index width need not match the array depth.
    always_comb begin
        cur_score = '0;
        for (int j = 0; j < NUM_CLASSES; j++) begin
            if (scan_idx == IDX_W'(j)) cur_score = score_buf[j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NUM_CLASSES; j++) score_buf[j] <= '0;
            best      <= '0;
            best_idx  <= '0;
            scan_idx  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
            class_idx <= '0;
            max_score <= '0;
`ifdef NN_ARGMAX_THRESHOLD_EN
            thresh_buf <= '0;
            reject     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        score_buf <= scores;
                        best      <= scores[0];
                        best_idx  <= '0;
                        scan_idx  <= FIRST_IDX;
                        valid     <= 1'b0;
                        busy      <= 1'b1;
`ifdef NN_ARGMAX_THRESHOLD_EN
                        thresh_buf <= threshold;
`endif
                    end
                end
                SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if (cur_score > best) begin
                        best     <= cur_score;
                        best_idx <= scan_idx;
                    end
                    if (scan_idx != LAST_IDX) scan_idx <= scan_idx + FIRST_IDX;
                end
                DONE: begin
                    done      <= 1'b1;
                    valid     <= 1'b1;
                    busy      <= 1'b0;
                    max_score <= best;
`ifdef NN_ARGMAX_THRESHOLD_EN
                    if (best < thresh_buf) begin
                        class_idx <= NO_WORD;
                        reject    <= 1'b1;
                    end else begin
                        class_idx <= best_idx;
                        reject    <= 1'b0;
                    end
`else
                    class_idx <= best_idx;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_argmax_classifier.sv
// Self-checking bench for nn_argmax_classifier: directed and random score vectors against an argmax model.
module tb_nn_argmax_classifier;

    localparam int N  = 10;
    localparam int W  = 48;
    localparam int IW = 8;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic signed [W-1:0] scores [0:N-1];
    logic busy, done, valid;
    logic [IW-1:0] class_idx;
    logic signed [W-1:0] max_score;
`ifdef NN_ARGMAX_THRESHOLD_EN
    logic signed [W-1:0] threshold = {1'b1, {(W-1){1'b0}}};
    logic reject;
`endif

    int testCount = 0;
    int failCount = 0;
    int expIdx;
    logic signed [W-1:0] expMax;

    nn_argmax_classifier #(.NUM_CLASSES(N), .DATA_W(W), .IDX_W(IW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .scores(scores),
`ifdef NN_ARGMAX_THRESHOLD_EN
        .threshold(threshold),
        .reject(reject),
`endif
        .busy(busy),
        .done(done),
        .valid(valid),
        .class_idx(class_idx),
        .max_score(max_score)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: largest value first, then the first position holding it.
    task automatic modelArgmax(output int idx, output logic signed [W-1:0] mx);
        mx = scores[0];
        for (int i = 1; i < N; i++) mx = (scores[i] > mx) ? scores[i] : mx;
        idx = -1;
        for (int i = N - 1; i >= 0; i--) if (scores[i] == mx) idx = i;
`ifdef NN_ARGMAX_THRESHOLD_EN
        if (mx < threshold) idx = N;
`endif
    endtask

    task automatic applyStimulus();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic setScores(input int v0, v1, v2, v3, v4, v5, v6, v7, v8, v9);
        int vals [0:N-1];
        vals = '{v0, v1, v2, v3, v4, v5, v6, v7, v8, v9};
        for (int i = 0; i < N; i++) scores[i] = W'(vals[i]);
    endtask

    task automatic runAndCheck(input string tag);
        int n;
        modelArgmax(expIdx, expMax);
        applyStimulus();
        checkOutput({tag, " busy_after_start"}, 64'(busy), 64'(1));
        checkOutput({tag, " valid_cleared"}, 64'(valid), 64'(0));
        n = 0;
        while (!done && n < 4 * N) begin
            tick();
            n++;
        end
        checkOutput({tag, " latency"}, 64'(n), 64'(N));
        checkOutput({tag, " class_idx"}, 64'(class_idx), 64'(expIdx));
        checkOutput({tag, " max_score"}, 64'(max_score), 64'(expMax));
        checkOutput({tag, " busy_at_done"}, 64'(busy), 64'(0));
`ifdef NN_ARGMAX_THRESHOLD_EN
        checkOutput({tag, " reject"}, 64'(reject), 64'(expIdx == N));
`endif
        tick();
        checkOutput({tag, " done_one_cycle"}, 64'(done), 64'(0));
        checkOutput({tag, " valid_held"}, 64'(valid), 64'(1));
    endtask

    initial begin
        int doneCount, doneAt, firstAt, n;
        logic [63:0] rv;

        setScores(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        checkOutput("reset busy", 64'(busy), 64'(0));
        checkOutput("reset done", 64'(done), 64'(0));
        checkOutput("reset valid", 64'(valid), 64'(0));
        checkOutput("reset class_idx", 64'(class_idx), 64'(0));
        checkOutput("reset max_score", 64'(max_score), 64'(0));

        setScores(3, 9, 2, 50, 7, 0, 0, 1, 49, 4);
        runAndCheck("directed");
        checkOutput("directed idx_value", 64'(class_idx), 64'(3));
        checkOutput("directed max_value", 64'(max_score), 64'(50));

        setScores(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        runAndCheck("all_zero");
        checkOutput("all_zero idx_value", 64'(class_idx), 64'(0));

        setScores(5, 12, 12, 1, 0, 0, 0, 0, 0, 0);
        runAndCheck("tie");
        checkOutput("tie idx_value", 64'(class_idx), 64'(1));

        setScores(-7, -3, -900, -3, -50, -4, -100, -8, -9, -10);
        runAndCheck("negative");
        checkOutput("negative idx_value", 64'(class_idx), 64'(1));

        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < N; i++) begin
                rv = {$urandom, $urandom};
                case (r % 3)
                    0:       scores[i] = rv[W-1:0];
                    1:       scores[i] = W'(int'($urandom_range(0, 6)) - 3);
                    default: scores[i] = -W'($urandom_range(1, 1000));
                endcase
            end
            runAndCheck($sformatf("random%0d", r));
        end

        // Snapshot isolation: inputs change and start re-pulses mid-scan.
        setScores(3, 9, 2, 50, 7, 0, 0, 1, 49, 4);
        modelArgmax(expIdx, expMax);
        applyStimulus();
        doneCount = 0;
        doneAt = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 2) setScores(0, 0, 0, 0, 0, 0, 0, 0, 0, 100);
            if (c == 4) start = 1'b1;
            if (c == 5) start = 1'b0;
            if (done) begin
                doneCount++;
                doneAt = c;
            end
        end
        checkOutput("snapshot done_count", 64'(doneCount), 64'(1));
        checkOutput("snapshot done_at", 64'(doneAt), 64'(N));
        checkOutput("snapshot class_idx", 64'(class_idx), 64'(expIdx));
        checkOutput("snapshot max_score", 64'(max_score), 64'(expMax));

        // Reset in the middle of a scan.
        setScores(1, 2, 3, 4, 5, 6, 7, 8, 9, 10);
        applyStimulus();
        for (int c = 1; c <= 4; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midreset busy", 64'(busy), 64'(0));
        checkOutput("midreset done", 64'(done), 64'(0));
        checkOutput("midreset valid", 64'(valid), 64'(0));
        checkOutput("midreset class_idx", 64'(class_idx), 64'(0));
        checkOutput("midreset max_score", 64'(max_score), 64'(0));
        doneCount = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (done) doneCount++;
        end
        checkOutput("midreset no_done", 64'(doneCount), 64'(0));
        runAndCheck("after_reset");

        // Start held high: results repeat every N+1 cycles.
        setScores(4, -2, 17, 17, 0, 3, 16, -20, 1, 2);
        modelArgmax(expIdx, expMax);
        start = 1'b1;
        n = 0;
        firstAt = -1;
        doneCount = 0;
        while (doneCount < 2 && n < 6 * N) begin
            tick();
            n++;
            if (done) begin
                doneCount++;
                if (doneCount == 1) firstAt = n;
            end
        end
        start = 1'b0;
        checkOutput("b2b done_count", 64'(doneCount), 64'(2));
        checkOutput("b2b first_latency", 64'(firstAt), 64'(N + 1));
        checkOutput("b2b period", 64'(n - firstAt), 64'(N + 1));
        checkOutput("b2b class_idx", 64'(class_idx), 64'(expIdx));
        for (int c = 0; c < 3; c++) tick();
        checkOutput("b2b idle_after", 64'(busy), 64'(0));

`ifdef NN_ARGMAX_THRESHOLD_EN
        setScores(3, 9, 2, 50, 7, 0, 0, 1, 49, 4);
        threshold = W'(60);
        runAndCheck("thresh_reject");
        checkOutput("thresh_reject idx_value", 64'(class_idx), 64'(N));
        checkOutput("thresh_reject flag", 64'(reject), 64'(1));
        checkOutput("thresh_reject max_value", 64'(max_score), 64'(50));
        threshold = W'(40);
        runAndCheck("thresh_accept");
        checkOutput("thresh_accept idx_value", 64'(class_idx), 64'(3));
        checkOutput("thresh_accept flag", 64'(reject), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
